// File: rtl/serial_frame_deframer.sv
// Sync-hunting serial deframer: finds SYNC_PAT and shifts in a PAYLOAD_W-bit word MSB-first.
// Words go out through a 2-entry FIFO. Define PARITY_CHECK_EN to append and check an even-parity bit.
module serial_frame_deframer #(
    parameter int unsigned           SYNC_W    = 8,
    parameter logic [SYNC_W-1:0]     SYNC_PAT  = 8'hA5,
    parameter int unsigned           PAYLOAD_W = 8,
    parameter int unsigned           DROP_W    = 8
) (
    input  logic                 clki,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_vld,
    output logic [PAYLOAD_W-1:0] word_data,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 locked,
    output logic                 ovf,
    output logic [DROP_W-1:0]    drop_cnt,
    output logic                 perr
);

    localparam int unsigned         CNT_W    = $clog2(PAYLOAD_W);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PAYLOAD_W - 1);

    typedef enum logic [1:0] {StHunt, StData, StPar} state_e;

    state_e                 state_q, state_d;
    // The oldest sync bit is only ever compared, never stored.
    logic [SYNC_W-2:0]      shreg_q, shreg_d;
    logic [SYNC_W-1:0]      shifted;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PAYLOAD_W-1:0]   asm_q, asm_d;
    logic                   push;
    logic                   par_fail;
    logic [PAYLOAD_W-1:0]   push_word;

    assign shifted = {shreg_q, bit_in};

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        push      = 1'b0;
        par_fail  = 1'b0;
        push_word = {asm_q[PAYLOAD_W-2:0], bit_in};
        unique case (state_q)
            StHunt: begin
                if (bit_vld) begin
                    if (shifted == SYNC_PAT) begin
                        state_d = StData;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end else begin
                        shreg_d = shifted[SYNC_W-2:0];
                    end
                end
            end
            StData: begin
                if (bit_vld) begin
                    asm_d = {asm_q[PAYLOAD_W-2:0], bit_in};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d = StPar;
`else
                        state_d = StHunt;
                        shreg_d = '0;
                        push    = 1'b1;
`endif
                    end
                end
            end
            StPar: begin
`ifdef PARITY_CHECK_EN
                push_word = asm_q;
                if (bit_vld) begin
                    state_d = StHunt;
                    shreg_d = '0;
                    if ((^asm_q ^ bit_in) == 1'b0) begin
                        push = 1'b1;
                    end else begin
                        par_fail = 1'b1;
                    end
                end
`else
                state_d = StHunt;
                shreg_d = '0;
`endif
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state_q <= StHunt;
            shreg_q <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
        end
    end

    assign locked = (state_q == StData) || (state_q == StPar);

    // Output FIFO: two entries, one-bit pointers, explicit occupancy.
    logic [PAYLOAD_W-1:0] mem_q [2];
    logic                 rd_ptr_q, wr_ptr_q;
    logic [1:0]           fill_q;
    logic                 pop, full, accept, drop;
    logic                 ovf_q, perr_q;
    logic [DROP_W-1:0]    drop_q;

    assign pop    = word_valid & word_ready;
    assign full   = (fill_q == 2'd2);
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            fill_q   <= 2'd0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (accept && !pop) begin
                fill_q <= fill_q + 2'd1;
            end else if (!accept && pop) begin
                fill_q <= fill_q - 2'd1;
            end
            ovf_q  <= drop;
            perr_q <= par_fail;
            if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
        end
    end

    assign word_data  = mem_q[rd_ptr_q];
    assign word_valid = (fill_q != 2'd0);
    assign ovf        = ovf_q;
    assign perr       = perr_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_serial_frame_deframer.sv
// Directed and randomized bench for serial_frame_deframer; follows PARITY_CHECK_EN if defined.
module tb_serial_frame_deframer;

`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clki = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_vld = 1'b0;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready = 1'b0;
    logic       locked;
    logic       ovf;
    logic [7:0] drop_cnt;
    logic       perr;

    serial_frame_deframer dut (
        .clki       (clki),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_vld    (bit_vld),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .locked     (locked),
        .ovf        (ovf),
        .drop_cnt   (drop_cnt),
        .perr       (perr)
    );

    always #5 clki = ~clki;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int lock_hi;
    logic [7:0] got[$];
    logic       sent[$];
    logic [7:0] expw[$];

    // Every word the consumer actually accepts.
    always @(posedge clki) begin
        if (!rst && word_valid && word_ready) got.push_back(word_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_got(input string tag, input logic [7:0] w);
        logic [7:0] v;
        v = (got.size() != 0) ? got.pop_front() : 8'hxx;
        check(tag, v, w);
    endtask

    task automatic step(input logic b, input logic v);
        bit_in  = b;
        bit_vld = v;
        @(posedge clki);
        #1;
        if (locked) lock_hi++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] x);
        for (int i = 7; i >= 0; i--) step(x[i], 1'b1);
    endtask

    // Sync + payload (+ correct parity); optionally raise word_ready for the final bit only.
    task automatic send_frame(input logic [7:0] p, input bit pop_last);
        lock_hi = 0;
        send_byte(SYNC);
        for (int i = 7; i >= 1; i--) step(p[i], 1'b1);
        if (PAR_EN) begin
            step(p[0], 1'b1);
            if (pop_last) word_ready = 1'b1;
            step(^p, 1'b1);
        end else begin
            if (pop_last) word_ready = 1'b1;
            step(p[0], 1'b1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bit_vld = 1'b0;
        #12;
        rst = 1'b0;
        @(posedge clki);
        #1;
        got.delete();
    endtask

    // Reference: scan the consumed bit stream for sync windows, then take whole frames.
    task automatic run_model();
        logic [7:0] win;
        int         i, n, need;
        logic [7:0] w;
        logic       par;
        win = '0;
        i = 0;
        n = sent.size();
        need = 8 + (PAR_EN ? 1 : 0);
        expw.delete();
        while (i < n) begin
            win = {win[6:0], sent[i]};
            i++;
            if (win == SYNC) begin
                if (i + need > n) break;
                for (int k = 0; k < 8; k++) w[7-k] = sent[i+k];
                par = PAR_EN ? sent[i+8] : 1'b0;
                i += need;
                if (!PAR_EN || ((^w ^ par) == 1'b0)) expw.push_back(w);
                win = '0;
            end
        end
    endtask

    task automatic rstep(input logic b);
        while ($urandom_range(0, 3) == 0) begin
            word_ready = ($urandom_range(0, 3) != 0);
            step(1'($urandom), 1'b0);
        end
        word_ready = ($urandom_range(0, 3) != 0);
        step(b, 1'b1);
        sent.push_back(b);
    endtask

    initial begin
        string tag;
        int    nframe;
        logic [7:0] p;
        do_reset();
        check("rst word_valid", word_valid, 0);
        check("rst word_data", word_data, 0);
        check("rst locked", locked, 0);
        check("rst ovf", ovf, 0);
        check("rst drop_cnt", drop_cnt, 0);
        check("rst perr", perr, 0);

        // 1: single frame, consumer always ready
        word_ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        check("t1 valid after last bit", word_valid, 1);
        check("t1 data", word_data, 8'h3C);
        check("t1 unlocked", locked, 0);
        check("t1 locked cycles", lock_hi, 8 + (PAR_EN ? 1 : 0));
        idle(1);
        check("t1 popped", word_valid, 0);
        expect_got("t1 word", 8'h3C);

        // 2: noise, then a frame
        lock_hi = 0;
        send_byte(8'hFF);
        send_byte(8'h00);
        check("t2 noise never locks", lock_hi, 0);
        send_frame(8'h81, 1'b0);
        check("t2 locked cycles", lock_hi, 8 + (PAR_EN ? 1 : 0));
        idle(2);
        expect_got("t2 word", 8'h81);
        check("t2 count", got.size(), 0);

        // 3: overflow with consumer stalled
        word_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        check("t3 head", word_data, 8'h11);
        check("t3 ovf before", ovf, 0);
        send_frame(8'h33, 1'b0);
        check("t3 ovf pulse", ovf, 1);
        check("t3 drop_cnt", drop_cnt, 1);
        idle(1);
        check("t3 ovf cleared", ovf, 0);
        check("t3 head stable", word_data, 8'h11);
        word_ready = 1'b1;
        idle(3);
        expect_got("t3 pop0", 8'h11);
        expect_got("t3 pop1", 8'h22);
        check("t3 count", got.size(), 0);
        check("t3 empty", word_valid, 0);

        // 4: push into a full FIFO on the same edge as a pop
        word_ready = 1'b0;
        send_frame(8'h44, 1'b0);
        send_frame(8'h55, 1'b0);
        send_frame(8'h66, 1'b1);
        check("t4 no ovf", ovf, 0);
        check("t4 drop_cnt kept", drop_cnt, 1);
        check("t4 head", word_data, 8'h55);
        idle(3);
        expect_got("t4 pop0", 8'h44);
        expect_got("t4 pop1", 8'h55);
        expect_got("t4 pop2", 8'h66);
        check("t4 count", got.size(), 0);

        // 5: asynchronous reset mid-payload with a word still queued
        word_ready = 1'b0;
        send_frame(8'h77, 1'b0);
        send_byte(SYNC);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t5 rst locked", locked, 0);
        check("t5 rst valid", word_valid, 0);
        check("t5 rst data", word_data, 0);
        check("t5 rst drop_cnt", drop_cnt, 0);
        #1 rst = 1'b0;
        word_ready = 1'b1;
        send_frame(8'h5A, 1'b0);
        idle(2);
        expect_got("t5 word", 8'h5A);
        check("t5 count", got.size(), 0);

`ifdef PARITY_CHECK_EN
        // 6: parity accept and reject
        send_byte(SYNC);
        send_byte(8'h07);
        step(1'b1, 1'b1);
        check("t6 no perr", perr, 0);
        idle(2);
        expect_got("t6 word", 8'h07);
        send_byte(SYNC);
        send_byte(8'h07);
        step(1'b0, 1'b1);
        check("t6 perr pulse", perr, 1);
        check("t6 no word", word_valid, 0);
        idle(1);
        check("t6 perr cleared", perr, 0);
        check("t6 drop_cnt", drop_cnt, 0);
        idle(2);
        check("t6 count", got.size(), 0);
`endif

        // Randomized stream against the reference scanner
        do_reset();
        sent.delete();
        for (int f = 0; f < 60; f++) begin
            nframe = $urandom_range(0, 20);
            for (int k = 0; k < nframe; k++) rstep(1'($urandom));
            if ($urandom_range(0, 3) != 0) begin
                p = 8'($urandom);
                for (int k = 7; k >= 0; k--) rstep(SYNC[k]);
                for (int k = 7; k >= 0; k--) rstep(p[k]);
                if (PAR_EN) rstep((^p) ^ ($urandom_range(0, 3) == 0));
            end
        end
        for (int k = 0; k < 20; k++) rstep(1'b0);
        word_ready = 1'b1;
        idle(6);
        run_model();
        check("rnd word count", got.size(), expw.size());
        check("rnd drop_cnt", drop_cnt, 0);
        for (int k = 0; k < expw.size(); k++) begin
            tag = $sformatf("rnd word %0d", k);
            expect_got(tag, expw[k]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
